// File: rtl/ans_freq_table.sv
// ans_freq_table: symbol-frequency table with PMF / CMF / inverse-CMF lookup
// for the ANS decoder read port. Counts are loaded over the cfg port and an
// inclusive cumulative table is rebuilt one symbol per cycle on commit.
// Optional macro ICMF_BSEARCH_EN: inverse-CMF uses a fixed-latency binary
// search over the cumulative table instead of the default linear scan.
module ans_freq_table #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 8,
    parameter int SYM_COUNT = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     read_type,
    input  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result,
    output logic                           read_rdy,
    input  logic                           cfg_wr_en,
    input  logic [SYM_WIDTH-1:0]           cfg_sym,
    input  logic [CNT_WIDTH-1:0]           cfg_cnt,
    input  logic                           cfg_commit,
    output logic                           table_vld
);

    localparam int RW = CNT_WIDTH + SYM_WIDTH;
    localparam logic [SYM_WIDTH-1:0] LAST = SYM_WIDTH'(SYM_COUNT - 1);
    localparam logic [RW-1:0] SYM_COUNT_Q = RW'(SYM_COUNT);
    localparam logic [1:0] RT_NONE = 2'b00;
    localparam logic [1:0] RT_PMF  = 2'b01;
    localparam logic [1:0] RT_CMF  = 2'b10;
    localparam logic [1:0] RT_ICMF = 2'b11;

    typedef enum logic [1:0] {IDLE, BUILD, LOOKUP} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_WIDTH-1:0]   count [SYM_COUNT];
    logic [RW-1:0]          cum   [SYM_COUNT];
    logic [SYM_WIDTH-1:0]   build_idx;
    logic [RW-1:0]          build_sum;
    logic                   done;
    logic [1:0]             lat_type;
    logic [RW-1:0]          lat_query;
    logic                   start;
    logic                   lookup_finish;
    logic                   cfg_sym_ok;
    logic                   query_ok;
    logic [SYM_WIDTH-1:0]   query_idx;
    logic [SYM_WIDTH-1:0]   icmf_result;

`ifdef ICMF_BSEARCH_EN
    localparam int STEP_W = $clog2(SYM_WIDTH + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SYM_WIDTH);

    logic [SYM_WIDTH-1:0]   bs_lo;
    logic [SYM_WIDTH-1:0]   bs_hi;
    logic [SYM_WIDTH:0]     bs_sum;
    logic [SYM_WIDTH-1:0]   bs_mid;
    logic [STEP_W-1:0]      bs_step;
`else
    logic [SYM_WIDTH-1:0]   scan_idx;
`endif

    assign cfg_sym_ok = ({1'b0, cfg_sym} < (SYM_WIDTH+1)'(SYM_COUNT));
    assign query_ok   = (lat_query < SYM_COUNT_Q);
    assign query_idx  = lat_query[SYM_WIDTH-1:0];
    assign start      = table_vld && (read_type != RT_NONE) && !done;
    assign read_rdy   = done && (read_type == lat_type) && (read_query == lat_query);

    // Running sum for the symbol currently being folded into the cumulative table
    always_comb begin
        build_sum = RW'(count[build_idx]);
        if (build_idx != '0) begin
            build_sum = build_sum + cum[build_idx - 1'b1];
        end
    end

`ifdef ICMF_BSEARCH_EN
    assign bs_sum      = {1'b0, bs_lo} + {1'b0, bs_hi};
    assign bs_mid      = SYM_WIDTH'(bs_sum >> 1);
    assign icmf_result = bs_lo;

    // Binary search finishes after a fixed number of halving steps
    always_comb begin
        lookup_finish = 1'b1;
        if (lat_type == RT_ICMF) begin
            lookup_finish = (bs_step == STEP_LAST);
        end
    end
`else
    assign icmf_result = scan_idx;

    // Linear scan stops at the first cumulative value above the query or at the last symbol
    always_comb begin
        lookup_finish = 1'b1;
        if (lat_type == RT_ICMF) begin
            lookup_finish = (cum[scan_idx] > lat_query) || (scan_idx == LAST);
        end
    end
`endif

    // State register; reset drops straight into building the uniform table
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BUILD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: config activity overrides any build or lookup in progress
    always_comb begin
        next_state = state;
        if (cfg_commit) begin
            next_state = BUILD;
        end else if (cfg_wr_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                BUILD:   if (build_idx == LAST) next_state = IDLE;
                IDLE:    if (start) next_state = LOOKUP;
                LOOKUP:  if (lookup_finish) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Count storage, cumulative build, request latching and answer registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_COUNT; i++) begin
                count[i] <= CNT_WIDTH'(1);
                cum[i]   <= '0;
            end
            build_idx   <= '0;
            table_vld   <= 1'b0;
            done        <= 1'b0;
            read_result <= '0;
            lat_type    <= RT_NONE;
            lat_query   <= '0;
`ifdef ICMF_BSEARCH_EN
            bs_lo       <= '0;
            bs_hi       <= '0;
            bs_step     <= '0;
`else
            scan_idx    <= '0;
`endif
        end else begin
            if (cfg_wr_en && cfg_sym_ok) begin
                count[cfg_sym] <= cfg_cnt;
            end
            if (cfg_wr_en || cfg_commit) begin
                table_vld <= 1'b0;
                done      <= 1'b0;
                build_idx <= '0;
            end else begin
                case (state)
                    BUILD: begin
                        cum[build_idx] <= build_sum;
                        if (build_idx == LAST) begin
                            build_idx <= '0;
                            table_vld <= 1'b1;
                        end else begin
                            build_idx <= build_idx + 1'b1;
                        end
                    end
                    IDLE: begin
                        if (done && !read_rdy) begin
                            done <= 1'b0;
                        end else if (start) begin
                            lat_type  <= read_type;
                            lat_query <= read_query;
`ifdef ICMF_BSEARCH_EN
                            bs_lo     <= '0;
                            bs_hi     <= LAST;
                            bs_step   <= '0;
`else
                            scan_idx  <= '0;
`endif
                        end
                    end
                    LOOKUP: begin
                        if (lookup_finish) begin
                            done <= 1'b1;
                            case (lat_type)
                                RT_PMF:  read_result <= query_ok ? RW'(count[query_idx]) : '0;
                                RT_CMF:  read_result <= query_ok ? cum[query_idx] : '0;
                                RT_ICMF: read_result <= RW'(icmf_result);
                                default: read_result <= '0;
                            endcase
                        end else begin
`ifdef ICMF_BSEARCH_EN
                            bs_step <= bs_step + 1'b1;
                            if (bs_lo < bs_hi) begin
                                if (cum[bs_mid] > lat_query) begin
                                    bs_hi <= bs_mid;
                                end else begin
                                    bs_lo <= bs_mid + 1'b1;
                                end
                            end
`else
                            scan_idx <= scan_idx + 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ans_freq_table.md
Name: ans_freq_table

Overview:
- Symbol-frequency table and lookup engine serving the ANS decoder's read port; sits directly downstream of the decoder's read_type/read_query request bus.
- Holds per-symbol counts and builds an inclusive cumulative table.
- Answers PMF, CMF and inverse-CMF (ICMF) queries with a level handshake.
- Counts are loaded through a simple config write port.

Parameters:
- SYM_WIDTH, 4, symbol index width
- CNT_WIDTH, 8, per-symbol count width
- SYM_COUNT, 16, number of symbols (≤ 2^SYM_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- read_type  in  2  00 NONE, 01 PMF, 10 CMF, 11 ICMF
- read_query  in  CNT_WIDTH+SYM_WIDTH  symbol index (PMF/CMF) or cumulative value (ICMF)
- read_result  out  CNT_WIDTH+SYM_WIDTH  answer, zero-extended
- read_rdy  out  1  read_result valid for the currently presented type/query
- cfg_wr_en  in  1  write cfg_cnt into count[cfg_sym]
- cfg_sym  in  SYM_WIDTH  symbol to write
- cfg_cnt  in  CNT_WIDTH  count value
- cfg_commit  in  1  pulse: rebuild cumulative table
- table_vld  out  1  cumulative table consistent with counts

Behaviour:
- Definitions:
  - CMF(s) = sum of count[0..s], inclusive.
  - PMF(s) = count[s].
  - ICMF(q) = smallest s with CMF(s) > q.
  - Sums are CNT_WIDTH+SYM_WIDTH wide; no overflow is possible.
- Reset:
  - count[i]=1 for all i; read_result=0, read_rdy=0, table_vld=0; FSM enters BUILD automatically.
- FSM states IDLE, BUILD, LOOKUP:
  - BUILD: one symbol per cycle, cum[i]=cum[i-1]+count[i]. Takes SYM_COUNT cycles, then table_vld=1 and FSM goes to IDLE.
  - IDLE: when table_vld and read_type≠NONE and no answer is held, latch type/query and go to LOOKUP.
  - LOOKUP, PMF/CMF: result is registered the next cycle, so read_rdy is high 2 cycles after the request is presented.
  - LOOKUP, ICMF: linear scan from s=0, one compare per cycle. Latency is s+2 cycles for a result of s.
  - On completion: register read_result, set internal done flag, return to IDLE holding the answer.
- read_rdy is combinational: done AND read_type==latched type AND read_query==latched query.
  - Changing the query or dropping to NONE deasserts read_rdy in the same cycle.
  - Either event clears done at the next edge, so a new request may be issued the cycle after NONE.
- read_result holds its last value after done clears.
- Requests presented while table_vld=0 pend; read_rdy stays 0 until the build completes and the lookup finishes.
- Range rules:
  - PMF/CMF with query ≥ SYM_COUNT (including all-ones wrap) → result 0.
  - ICMF with query ≥ CMF(SYM_COUNT-1) → result SYM_COUNT-1.
  - ICMF result is a symbol index, zero-extended.
- Config port:
  - cfg_wr_en: updates the count, clears table_vld and done, aborts any LOOKUP to IDLE. Pending requests are not answered until rebuild.
  - cfg_commit: starts BUILD from symbol 0; a commit during BUILD restarts it.
  - cfg_wr_en and cfg_commit in the same cycle: the write lands first, then BUILD starts.
  - cfg_sym ≥ SYM_COUNT: write ignored, but still clears table_vld.
- A zero count is legal. ICMF never returns a zero-count symbol unless query ≥ total.
- rst_n low mid-lookup or mid-build: full reset to the reset state above.

Optional Feature:
- ICMF_BSEARCH_EN defined: ICMF uses binary search over cum[]. Fixed latency SYM_WIDTH+2 cycles regardless of result; same results as the scan.
- Undefined: linear scan as above. PMF/CMF timing is unaffected either way.

Test Plan:
- Reset, hold CMF query 15 → table_vld after 16 cycles; read_rdy with result 16 (uniform counts); result stays while held.
- Program counts 0..3 = 5, 0, 3, 8 (others 0), commit; query ICMF 4, 5, 8, 15 → 0, 2, 3, 3. ICMF 20 → 15.
- Same table: PMF 2 → 3; CMF 1 → 5; CMF with query all-ones → 0.
- Decoder-style sequence: PMF answered, drop to NONE → read_rdy=0 in that same cycle. CMF issued the next cycle is answered correctly.
- cfg_wr_en during an in-flight ICMF → table_vld falls, no read_rdy. After commit, the held query is answered with the new-table value.
- Build with and without ICMF_BSEARCH_EN: identical results over all queries 0..total; binary-search latency constant at 6 cycles.
